// File: rtl/bju_recovery_ctrl.sv
// Branch-order and misprediction-recovery controller for the BJU.
// Hands out branch IDs in program order from a small ring and accepts
// resolutions in any order. Retirement is in order from the head. A
// mispredict on a live ID produces a one-cycle registered fetch redirect
// and a mask of every younger ID it kills. Allocation is then held for a
// fixed refill window.
module bju_recovery_ctrl #(
    parameter int NUM_BR      = 4,
    parameter int ID_W        = $clog2(NUM_BR),
    parameter int RECOVER_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    output logic [ID_W-1:0]   alloc_id_o,
    input  logic              res_valid_i,
    input  logic [ID_W-1:0]   res_id_i,
    input  logic              res_mispredict_i,
    input  logic [31:0]       res_target_i,
    output logic              redirect_valid_o,
    output logic [31:0]       redirect_pc_o,
    output logic              kill_valid_o,
    output logic [NUM_BR-1:0] kill_mask_o,
    output logic [ID_W:0]     inflight_cnt_o
);

    localparam int CNT_W = ID_W + 1;
    localparam int BLK_W = $clog2(RECOVER_CYC) + 1;
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(RECOVER_CYC - 1);

    typedef enum logic {
        RUN   = 1'b0,
        BLOCK = 1'b1
    } state_t;

    state_t              state_r;
    logic [BLK_W-1:0]    blk_cnt_r;
    logic [ID_W-1:0]     head_r;
    logic [ID_W-1:0]     tail_r;
    logic [CNT_W-1:0]    count_r;
    logic [NUM_BR-1:0]   valid_r;
    logic [NUM_BR-1:0]   resolved_r;
    logic                redirect_valid_r;
    logic [31:0]         redirect_pc_r;
    logic                kill_valid_r;
    logic [NUM_BR-1:0]   kill_mask_r;

    logic                alloc_ready_s;
    logic                alloc_fire_s;
    logic                res_hit_s;
    logic                mispred_s;
    logic                retire_s;
    logic [ID_W-1:0]     res_age_s;
    logic [NUM_BR-1:0]   valid_n_s;
    logic [NUM_BR-1:0]   resolved_n_s;
    logic [NUM_BR-1:0]   kill_n_s;
    logic [ID_W-1:0]     head_n_s;
    logic [ID_W-1:0]     tail_n_s;
    logic [CNT_W-1:0]    count_n_s;

    // The grant depends only on registered state, so a same-cycle retire never frees a slot early.
    assign alloc_ready_s = (state_r == RUN) && (count_r < CNT_W'(NUM_BR));
    assign alloc_fire_s  = alloc_valid_i && alloc_ready_s;
    // Resolves on IDs that are not live (stale or already killed) are dropped here.
    assign res_hit_s     = res_valid_i && valid_r[res_id_i];
    assign mispred_s     = res_hit_s && res_mispredict_i;
    assign res_age_s     = res_id_i - head_r;

    // Next-state of the ring: resolve, then allocate or kill (kill wins), then retire the head.
    always_comb begin
        valid_n_s    = valid_r;
        resolved_n_s = resolved_r;
        kill_n_s     = '0;
        if (res_hit_s) begin
            resolved_n_s[res_id_i] = 1'b1;
        end else begin
            resolved_n_s = resolved_n_s;
        end
        if (mispred_s) begin
            // The ID granted this same cycle sits at the old tail, so it is younger and dies too.
            for (int i = 0; i < NUM_BR; i++) begin
                if (((ID_W'(i) - head_r) > res_age_s) &&
                    (valid_r[i] || (alloc_fire_s && (ID_W'(i) == tail_r)))) begin
                    kill_n_s[i] = 1'b1;
                end else begin
                    kill_n_s[i] = 1'b0;
                end
            end
            valid_n_s    = valid_n_s & ~kill_n_s;
            resolved_n_s = resolved_n_s & ~kill_n_s;
        end else if (alloc_fire_s) begin
            valid_n_s[tail_r]    = 1'b1;
            resolved_n_s[tail_r] = 1'b0;
        end else begin
            valid_n_s = valid_n_s;
        end
        // The head is never younger than the offender, so a kill cannot remove it.
        retire_s = valid_n_s[head_r] && resolved_n_s[head_r];
        if (retire_s) begin
            valid_n_s[head_r]    = 1'b0;
            resolved_n_s[head_r] = 1'b0;
        end else begin
            valid_n_s = valid_n_s;
        end
        head_n_s = head_r + ID_W'(retire_s);
        if (mispred_s) begin
            tail_n_s  = res_id_i + ID_W'(1);
            count_n_s = CNT_W'(res_age_s) + CNT_W'(1) - CNT_W'(retire_s);
        end else begin
            tail_n_s  = tail_r + ID_W'(alloc_fire_s);
            count_n_s = count_r + CNT_W'(alloc_fire_s) - CNT_W'(retire_s);
        end
    end

    // Ring registers, recovery FSM and the registered redirect/kill outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r          <= RUN;
            blk_cnt_r        <= '0;
            head_r           <= '0;
            tail_r           <= '0;
            count_r          <= '0;
            valid_r          <= '0;
            resolved_r       <= '0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'h0;
            kill_valid_r     <= 1'b0;
            kill_mask_r      <= '0;
        end else if (flush_i) begin
            state_r          <= RUN;
            blk_cnt_r        <= '0;
            head_r           <= '0;
            tail_r           <= '0;
            count_r          <= '0;
            valid_r          <= '0;
            resolved_r       <= '0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'h0;
            kill_valid_r     <= 1'b0;
            kill_mask_r      <= '0;
        end else begin
            head_r           <= head_n_s;
            tail_r           <= tail_n_s;
            count_r          <= count_n_s;
            valid_r          <= valid_n_s;
            resolved_r       <= resolved_n_s;
            redirect_valid_r <= mispred_s;
            redirect_pc_r    <= mispred_s ? res_target_i : 32'h0;
            kill_valid_r     <= mispred_s;
            kill_mask_r      <= kill_n_s;
            if (mispred_s) begin
                // A new mispredict, even during BLOCK, restarts the refill window.
                state_r   <= BLOCK;
                blk_cnt_r <= BLK_LOAD;
            end else begin
                case (state_r)
                    RUN: begin
                        state_r   <= RUN;
                        blk_cnt_r <= '0;
                    end
                    BLOCK: begin
                        if (blk_cnt_r == '0) begin
                            state_r <= RUN;
                        end else begin
                            blk_cnt_r <= blk_cnt_r - BLK_W'(1);
                        end
                    end
                    default: begin
                        state_r   <= RUN;
                        blk_cnt_r <= '0;
                    end
                endcase
            end
        end
    end

    assign alloc_ready_o    = alloc_ready_s;
    assign alloc_id_o       = tail_r;
    assign redirect_valid_o = redirect_valid_r;
    assign redirect_pc_o    = redirect_pc_r;
    assign kill_valid_o     = kill_valid_r;
    assign kill_mask_o      = kill_mask_r;
    assign inflight_cnt_o   = count_r;

endmodule

// File: tb/tb_bju_recovery_ctrl.sv
// Testbench for bju_recovery_ctrl. It runs directed sequences first,
// then randomized traffic. Every cycle is checked against a queue-based
// model of the in-flight branches kept in program order.
module tb_bju_recovery_ctrl;

    localparam int NUM_BR      = 4;
    localparam int ID_W        = 2;
    localparam int RECOVER_CYC = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [ID_W-1:0]   alloc_id;
    logic              res_valid;
    logic [ID_W-1:0]   res_id;
    logic              res_mispredict;
    logic [31:0]       res_target;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              kill_valid;
    logic [NUM_BR-1:0] kill_mask;
    logic [ID_W:0]     inflight_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: live IDs oldest-first, with their resolved flags.
    int q_id[$];
    bit q_res[$];
    int next_id;
    int blk_left;
    bit exp_rv;
    int unsigned exp_pc;
    bit exp_kv;
    int exp_km;

    bju_recovery_ctrl #(
        .NUM_BR(NUM_BR), .ID_W(ID_W), .RECOVER_CYC(RECOVER_CYC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
        .res_valid_i(res_valid), .res_id_i(res_id), .res_mispredict_i(res_mispredict),
        .res_target_i(res_target),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .kill_valid_o(kill_valid), .kill_mask_o(kill_mask), .inflight_cnt_o(inflight_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_id.delete();
        q_res.delete();
        next_id  = 0;
        blk_left = 0;
        exp_rv   = 1'b0;
        exp_pc   = 0;
        exp_kv   = 1'b0;
        exp_km   = 0;
    endtask

    function automatic int find_pos(input int id);
        for (int j = 0; j < q_id.size(); j++) begin
            if (q_id[j] == id) return j;
        end
        return -1;
    endfunction

    // Compare all outputs against the model, advance the model, then clock.
    task automatic step();
        bit m_ready;
        bit fire;
        bit mp;
        int pos;
        int km;
        m_ready = (blk_left == 0) && (q_id.size() < NUM_BR);
        check_eq("alloc_ready", 32'(alloc_ready), 32'(m_ready));
        check_eq("alloc_id", 32'(alloc_id), 32'(next_id));
        check_eq("inflight_cnt", 32'(inflight_cnt), 32'(q_id.size()));
        check_eq("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
        check_eq("redirect_pc", redirect_pc, exp_pc);
        check_eq("kill_valid", 32'(kill_valid), 32'(exp_kv));
        check_eq("kill_mask", 32'(kill_mask), 32'(exp_km));
        if (flush) begin
            model_reset();
        end else begin
            fire = alloc_valid && m_ready;
            pos  = res_valid ? find_pos(int'(res_id)) : -1;
            mp   = (pos >= 0) && res_mispredict;
            km   = 0;
            if (pos >= 0) q_res[pos] = 1'b1;
            if (mp) begin
                for (int j = pos + 1; j < q_id.size(); j++) km |= (1 << q_id[j]);
                if (fire) km |= (1 << next_id);
                while (q_id.size() > pos + 1) begin
                    void'(q_id.pop_back());
                    void'(q_res.pop_back());
                end
                next_id = (int'(res_id) + 1) % NUM_BR;
            end else if (fire) begin
                q_id.push_back(next_id);
                q_res.push_back(1'b0);
                next_id = (next_id + 1) % NUM_BR;
            end
            if (q_id.size() > 0 && q_res[0]) begin
                void'(q_id.pop_front());
                void'(q_res.pop_front());
            end
            if (mp) blk_left = RECOVER_CYC;
            else if (blk_left > 0) blk_left--;
            exp_rv = mp;
            exp_pc = mp ? res_target : 0;
            exp_kv = mp;
            exp_km = km;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit av, input bit rv, input int rid, input bit rmp,
                       input logic [31:0] tgt, input bit fl);
        alloc_valid    = av;
        res_valid      = rv;
        res_id         = ID_W'(rid);
        res_mispredict = rmp;
        res_target     = tgt;
        flush          = fl;
        step();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; alloc_valid = 1'b0; res_valid = 1'b0;
        res_id = '0; res_mispredict = 1'b0; res_target = 32'h0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_ready", 32'(alloc_ready), 32'd1);

        // Fill and drain
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0);
        check_eq("full_ready", 32'(alloc_ready), 32'd0);
        check_eq("full_cnt", 32'(inflight_cnt), 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, i, 1'b0, 32'h0, 1'b0);
        check_eq("drained_cnt", 32'(inflight_cnt), 32'd0);

        // Out-of-order resolve: 0,1,2 in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 2, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1, 1'b0, 32'h0, 1'b0);
        check_eq("ooo_no_retire", 32'(inflight_cnt), 32'd3);
        cyc(1'b0, 1'b1, 0, 1'b0, 32'h0, 1'b0);
        check_eq("ooo_retire1", 32'(inflight_cnt), 32'd2);
        cyc(1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
        check_eq("ooo_retire3", 32'(inflight_cnt), 32'd0);

        // Flush with three in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
        check_eq("flush_cnt", 32'(inflight_cnt), 32'd0);
        check_eq("flush_ready", 32'(alloc_ready), 32'd1);

        // Mispredict kill on id 1 with 0..3 in flight
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1, 1'b1, 32'h8000_1000, 1'b0);
        check_eq("mp_redirect", 32'(redirect_valid), 32'd1);
        check_eq("mp_pc", redirect_pc, 32'h8000_1000);
        check_eq("mp_mask", 32'(kill_mask), 32'hC);
        check_eq("mp_tail", 32'(alloc_id), 32'd2);
        check_eq("mp_block1", 32'(alloc_ready), 32'd0);
        // Stale resolve on killed id 3
        cyc(1'b1, 1'b1, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check_eq("stale_redirect", 32'(redirect_valid), 32'd0);
        check_eq("stale_cnt", 32'(inflight_cnt), 32'd2);
        check_eq("mp_block2", 32'(alloc_ready), 32'd0);
        // Nested mispredict on id 0 while still blocked
        cyc(1'b0, 1'b1, 0, 1'b1, 32'h100, 1'b0);
        check_eq("nest_pc", redirect_pc, 32'h100);
        check_eq("nest_mask", 32'(kill_mask), 32'h2);
        check_eq("nest_block", 32'(alloc_ready), 32'd0);

        // Asynchronous reset mid-BLOCK, away from any clock edge
        #2 rst = 1'b1;
        #1;
        check_eq("arst_redirect", 32'(redirect_valid), 32'd0);
        check_eq("arst_mask", 32'(kill_mask), 32'd0);
        check_eq("arst_cnt", 32'(inflight_cnt), 32'd0);
        check_eq("arst_ready", 32'(alloc_ready), 32'd1);
        model_reset();
        alloc_valid = 1'b0; res_valid = 1'b0; res_mispredict = 1'b0; flush = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic; resolves on already-resolved live IDs are withheld
        for (int n = 0; n < 3000; n++) begin
            bit av, rv, rmp, fl;
            int rid, pos;
            av  = ($urandom_range(99) < 55);
            rv  = ($urandom_range(99) < 60);
            rid = $urandom_range(NUM_BR - 1);
            rmp = ($urandom_range(99) < 15);
            fl  = ($urandom_range(99) < 1);
            pos = find_pos(rid);
            if (pos >= 0 && q_res[pos]) rv = 1'b0;
            cyc(av, rv, rid, rmp, $urandom, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
